// File: rtl/spn_key_schedule.sv
// Round-key generator: expands a master key into NR+1 round keys, then streams
// them ascending (encrypt) or descending (decrypt) over a valid/ready handshake.
module spn_key_schedule #(
  parameter int DW = 16,
  parameter int KW = 32,
  parameter int NR = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [KW-1:0] key_in,
  input  logic          dir,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [DW-1:0] rk_data,
  output logic [3:0]    rk_index,
  output logic          rk_last,
  output logic          busy
);
  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k_reg;
  logic [3:0]    cnt, ptr, rcon;
  logic          dir_q;
  // 16 entries so the 4-bit pointers index the buffer without width games
  logic [DW-1:0] key_buf [16];

  assign rcon = cnt + 4'd1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key_valid)           state_nx = EXPAND;
      EXPAND:  if (cnt == LAST)         state_nx = STREAM;
      STREAM:  if (rk_ready && rk_last) state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k_reg <= '0;
      cnt   <= '0;
      ptr   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (key_valid) begin
          k_reg <= key_in;
          dir_q <= dir;
          cnt   <= '0;
        end
        EXPAND: begin
          k_reg <= {k_reg[KW-5:0], k_reg[KW-1:KW-4]} ^ {{(KW-4){1'b0}}, rcon};
          cnt   <= rcon;
          ptr   <= dir_q ? LAST : 4'd0;
        end
        STREAM: if (rk_ready && !rk_last)
          ptr <= dir_q ? ptr - 4'd1 : ptr + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == EXPAND)
      key_buf[cnt] <= k_reg[KW-1:KW-DW];
  end

  // Outputs decode registered state/ptr only; no input reaches an output.
  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rk_valid  = (state == STREAM);
  assign rk_data   = rk_valid ? key_buf[ptr] : '0;
  assign rk_index  = ptr;
  assign rk_last   = rk_valid && (dir_q ? (ptr == 4'd0) : (ptr == LAST));

endmodule

// File: tb/tb_spn_key_schedule.sv
// Directed, table-driven bench for spn_key_schedule (default parameters).
module tb_spn_key_schedule;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_in;
  logic        dir;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk_data;
  logic [3:0]  rk_index;
  logic        rk_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spn_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .dir(dir), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last), .busy(busy)
  );

  // exp[i] is the round key expected at rk_index i
  typedef struct {
    logic [31:0]      key;
    logic             dir;
    int               stall_idx;
    int               stall_n;
    bit               poke;
    logic [4:0][15:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns at the negedge right after the handshake edge.
  task automatic send_key(input logic [31:0] k, input logic d);
    key_valid = 1'b1;
    key_in    = k;
    dir       = d;
    @(negedge clk);
    key_valid = 1'b0;
    chk("busy_after_hs", 32'(busy), 32'd1);
    chk("key_ready_after_hs", 32'(key_ready), 32'd0);
  endtask

  task automatic wait_stream(output bit ok);
    int lat = 0;
    while (!rk_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    ok = rk_valid;
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    bit ok;
    int idx;
    send_key(v.key, v.dir);
    if (v.poke) begin
      key_valid = 1'b1;
      key_in    = 32'hFFFF_FFFF;
    end
    wait_stream(ok);
    if (!ok) begin
      key_valid = 1'b0;
      return;
    end
    for (int n = 0; n < 5; n++) begin
      idx = v.dir ? 4 - n : n;
      if (idx == v.stall_idx) begin
        rk_ready = 1'b0;
        for (int s = 0; s < v.stall_n; s++) begin
          chk($sformatf("v%0d_stall_data", vi), 32'(rk_data), 32'(v.exp[idx]));
          chk($sformatf("v%0d_stall_index", vi), 32'(rk_index), 32'(idx));
          @(negedge clk);
        end
        rk_ready = 1'b1;
      end
      chk($sformatf("v%0d_valid%0d", vi, n), 32'(rk_valid), 32'd1);
      chk($sformatf("v%0d_data%0d", vi, n), 32'(rk_data), 32'(v.exp[idx]));
      chk($sformatf("v%0d_index%0d", vi, n), 32'(rk_index), 32'(idx));
      chk($sformatf("v%0d_last%0d", vi, n), 32'(rk_last), 32'(n == 4));
      if (n == 4) key_valid = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("v%0d_end_valid", vi), 32'(rk_valid), 32'd0);
    chk($sformatf("v%0d_end_key_ready", vi), 32'(key_ready), 32'd1);
    chk($sformatf("v%0d_end_busy", vi), 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    chk({tag, "_rk_valid"}, 32'(rk_valid), 32'd0);
    chk({tag, "_rk_last"}, 32'(rk_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rk_data"}, 32'(rk_data), 32'h0);
    chk({tag, "_rk_index"}, 32'(rk_index), 32'h0);
  endtask

  initial begin
    bit ok;
    // 0x01234567 expands to 0123,1234,2345,3456,4567
    // 0xABCD0000 expands to ABCD,BCD0,CD00,D000,0000
    vecs[0] = '{32'h0123_4567, 1'b0, -1, 0, 1'b0, {16'h4567, 16'h3456, 16'h2345, 16'h1234, 16'h0123}};
    vecs[1] = '{32'h0123_4567, 1'b1, -1, 0, 1'b0, {16'h4567, 16'h3456, 16'h2345, 16'h1234, 16'h0123}};
    vecs[2] = '{32'h0123_4567, 1'b0,  2, 3, 1'b0, {16'h4567, 16'h3456, 16'h2345, 16'h1234, 16'h0123}};
    vecs[3] = '{32'h0123_4567, 1'b0, -1, 0, 1'b1, {16'h4567, 16'h3456, 16'h2345, 16'h1234, 16'h0123}};
    vecs[4] = '{32'hABCD_0000, 1'b1,  4, 2, 1'b1, {16'h0000, 16'hD000, 16'hCD00, 16'hBCD0, 16'hABCD}};

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; dir = 1'b0; rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset pulse while index 2 is on the bus (indices 0,1 already consumed)
    send_key(32'h0123_4567, 1'b0);
    wait_stream(ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      chk("mid_rst_pre_index", 32'(rk_index), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_outs("mid_rst");
      @(negedge clk);
      chk_reset_outs("mid_rst_hold");
    end
    run_vec(vecs[0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
